bus_arbiter_4: RTL and testbench
================================

BUS_ARBITER_4 -- requirements
Module: bus_arbiter_4

Interface
REQ-001 Parameter WIDTH, default 32: width of each data input and BUS_OUT.
REQ-002 Parameter MAX_HOLD, default 8: maximum consecutive GRANT cycles per owner, legal range 1-255.
REQ-003 CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 RST_N  input  1  reset, asynchronous, active-low.
REQ-005 REQ  input  4  per-requester request, bit i = requester i.
REQ-006 DONE  input  1  current owner signals transaction complete; ignored outside GRANT.
REQ-007 DATA0, DATA1, DATA2, DATA3  input  WIDTH each  requester data.
REQ-008 GNT  output  4  registered one-hot grant, or all zero.
REQ-009 SEL  output  2  registered index of current or last owner; drives shared 4:1 select.
REQ-010 BUS_VALID  output  1  registered, high while in GRANT.
REQ-011 BUS_OUT  output  WIDTH  combinational: DATA[SEL] when BUS_VALID=1, else 0.
REQ-012 TIMEOUT  output  1  registered one-cycle pulse on forced release.

Function
REQ-013 Block SHALL use a two-state FSM: IDLE and GRANT.
REQ-014 Block SHALL hold a 2-bit round-robin pointer PTR and an 8-bit hold counter HCNT.
REQ-015 In IDLE with REQ=0000, block SHALL remain in IDLE with GNT=0000 and BUS_VALID=0.
REQ-016 In IDLE with REQ!=0000, block SHALL select the first set REQ bit searching PTR, PTR+1, ... mod 4.
REQ-017 On that edge, block SHALL enter GRANT, set GNT to the winner's one-hot, set SEL to the winner's index, set BUS_VALID=1, and set HCNT=1.
REQ-018 GNT SHALL therefore appear one cycle after REQ is first sampled in IDLE.
REQ-019 In GRANT, release SHALL occur at the next edge when any of the following holds: DONE=1, owner REQ bit=0, or HCNT=MAX_HOLD.
REQ-020 On release, block SHALL enter IDLE, set GNT=0000, set BUS_VALID=0, set PTR=(owner+1) mod 4, set HCNT=0, and keep SEL at the owner index.
REQ-021 TIMEOUT SHALL pulse high for the first IDLE cycle only when release is caused by HCNT=MAX_HOLD with DONE=0 and owner REQ=1.
REQ-022 When DONE=1 coincides with HCNT=MAX_HOLD, DONE SHALL take precedence and TIMEOUT SHALL stay 0.
REQ-023 When no release condition holds in GRANT, HCNT SHALL increment by 1 and GNT, SEL and PTR SHALL hold.
REQ-024 At least one IDLE cycle SHALL separate consecutive grants, serving as the bus turnaround cycle, including regrant to the same requester.
REQ-025 Changes to non-owner REQ bits during GRANT SHALL have no effect until IDLE.
REQ-026 PTR SHALL wrap from 3 to 0.
REQ-027 GNT SHALL never have more than one bit set.

Reset
REQ-028 While RST_N=0, block SHALL asynchronously force the following, independent of CLK: state=IDLE, PTR=0, HCNT=0, GNT=0000, SEL=0, BUS_VALID=0, TIMEOUT=0, BUS_OUT=0.
REQ-029 Assertion of RST_N mid-GRANT SHALL drop GNT immediately, with no TIMEOUT pulse.
REQ-030 After RST_N deasserts, the first arbitration SHALL occur at the first rising edge with state=IDLE.

Verification
REQ-031 Reset: RST_N=0 with REQ=1111 and CLK toggling -> GNT=0000, SEL=0, BUS_VALID=0, BUS_OUT=0.
REQ-032 Single grant:
- Stimulus: REQ=0100, DATA2=32'hDEADBEEF.
- Next cycle: GNT=0100, SEL=2, BUS_OUT=32'hDEADBEEF.
- DONE=1 for one cycle: next cycle GNT=0000, BUS_OUT=0, SEL=2.
REQ-033 Round-robin: REQ=1111 held, DONE=1 in every GRANT cycle -> owners 0,1,2,3,0 in order, each grant lasting one cycle, with one IDLE cycle between grants.
REQ-034 Timeout:
- Stimulus: MAX_HOLD=8, REQ=0001 held, DONE=0.
- GNT=0001 for exactly 8 cycles, then IDLE with TIMEOUT=1 for one cycle, then regrant to requester 0.
REQ-035 Request drop: owner 3 granted and REQ[3] deasserted in GRANT -> next cycle GNT=0000, TIMEOUT=0, PTR=0.
REQ-036 Reset mid-grant: RST_N pulsed low while GNT=0010 -> GNT=0000 before the next CLK edge; after release, REQ=0010 is granted again starting from PTR=0.

Source files
------------

// File: rtl/bus_arbiter_4.sv
// Four-requester round-robin bus arbiter with a bounded hold time and a
// mandatory one-cycle IDLE turnaround between grants.
module bus_arbiter_4 #(
  parameter int WIDTH    = 32,
  parameter int MAX_HOLD = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [3:0]       REQ,
  input  logic             DONE,
  input  logic [WIDTH-1:0] DATA0,
  input  logic [WIDTH-1:0] DATA1,
  input  logic [WIDTH-1:0] DATA2,
  input  logic [WIDTH-1:0] DATA3,
  output logic [3:0]       GNT,
  output logic [1:0]       SEL,
  output logic             BUS_VALID,
  output logic [WIDTH-1:0] BUS_OUT,
  output logic             TIMEOUT,
  output logic             dbg_state,
  output logic [1:0]       dbg_ptr,
  output logic [7:0]       dbg_hcnt
);

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_GRANT = 1'b1;

  logic       state;
  logic [1:0] ptr;
  logic [7:0] hcnt;
  logic [1:0] win;
  logic [1:0] idx;
  logic       hold_max;
  logic       release_now;

  // Search PTR, PTR+1, ... mod 4; lower offsets are visited last so they win.
  always_comb begin
    win = ptr;
    idx = ptr;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (REQ[idx]) win = idx;
    end
  end

  // SEL always holds the owner's index while in GRANT.
  assign hold_max    = (hcnt == 8'(MAX_HOLD));
  assign release_now = DONE | ~REQ[SEL] | hold_max;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= ST_IDLE;
      ptr       <= 2'd0;
      hcnt      <= 8'd0;
      GNT       <= 4'b0000;
      SEL       <= 2'd0;
      BUS_VALID <= 1'b0;
      TIMEOUT   <= 1'b0;
    end else begin
      TIMEOUT <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (REQ != 4'b0000) begin
            state     <= ST_GRANT;
            GNT       <= 4'b0001 << win;
            SEL       <= win;
            BUS_VALID <= 1'b1;
            hcnt      <= 8'd1;
          end
        end
        ST_GRANT: begin
          if (release_now) begin
            state     <= ST_IDLE;
            GNT       <= 4'b0000;
            BUS_VALID <= 1'b0;
            ptr       <= SEL + 2'd1;
            hcnt      <= 8'd0;
            // DONE wins over a coincident hold limit: no timeout pulse then.
            TIMEOUT   <= hold_max & ~DONE & REQ[SEL];
          end else begin
            hcnt <= hcnt + 8'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    BUS_OUT = '0;
    if (BUS_VALID) begin
      case (SEL)
        2'd0:    BUS_OUT = DATA0;
        2'd1:    BUS_OUT = DATA1;
        2'd2:    BUS_OUT = DATA2;
        default: BUS_OUT = DATA3;
      endcase
    end
  end

  assign dbg_state = state;
  assign dbg_ptr   = ptr;
  assign dbg_hcnt  = hcnt;

endmodule

// File: tb/tb_bus_arbiter_4.sv
// Randomized bench for bus_arbiter_4: a cycle-level reference model feeds an
// expected queue that a separate monitor drains once per clock.
module tb_bus_arbiter_4;
  localparam int W  = 32;
  localparam int MH = 8;

  logic         CLK = 1'b0;
  logic         RST_N;
  logic [3:0]   REQ;
  logic         DONE;
  logic [W-1:0] d0, d1, d2, d3;
  logic [3:0]   GNT;
  logic [1:0]   SEL;
  logic         BUS_VALID;
  logic [W-1:0] BUS_OUT;
  logic         TIMEOUT;
  logic         dbg_state;
  logic [1:0]   dbg_ptr;
  logic [7:0]   dbg_hcnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected {GNT, SEL, BUS_VALID, TIMEOUT, BUS_OUT} after each clock edge.
  logic [W+7:0] exp_q[$];

  // Reference model: owner index (-1 = bus idle), pointer, cycles held.
  int m_owner, m_ptr, m_hold, m_sel;

  bus_arbiter_4 #(.WIDTH(W), .MAX_HOLD(MH)) dut (
    .CLK(CLK), .RST_N(RST_N), .REQ(REQ), .DONE(DONE),
    .DATA0(d0), .DATA1(d1), .DATA2(d2), .DATA3(d3),
    .GNT(GNT), .SEL(SEL), .BUS_VALID(BUS_VALID), .BUS_OUT(BUS_OUT),
    .TIMEOUT(TIMEOUT), .dbg_state(dbg_state), .dbg_ptr(dbg_ptr),
    .dbg_hcnt(dbg_hcnt)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_hold  = 0;
    m_sel   = 0;
  endtask

  function automatic logic [W-1:0] data_of(int i);
    case (i)
      0:       return d0;
      1:       return d1;
      2:       return d2;
      default: return d3;
    endcase
  endfunction

  // ---------------- reference model ----------------
  task automatic model_step(input logic [3:0] r, input logic d, output logic [W+7:0] e);
    logic         to;
    logic [3:0]   g;
    logic         v;
    logic [W-1:0] b;
    to = 1'b0;
    if (m_owner < 0) begin
      if (r != 4'b0000) begin
        for (int k = 0; k < 4; k++) begin
          if (m_owner < 0 && r[(m_ptr + k) % 4]) m_owner = (m_ptr + k) % 4;
        end
        m_sel  = m_owner;
        m_hold = 1;
      end
    end else begin
      if (d || !r[m_owner] || m_hold == MH) begin
        to      = !d && r[m_owner] && (m_hold == MH);
        m_ptr   = (m_owner + 1) % 4;
        m_owner = -1;
        m_hold  = 0;
      end else begin
        m_hold = m_hold + 1;
      end
    end
    v = (m_owner >= 0);
    g = v ? (4'b0001 << m_owner) : 4'b0000;
    b = v ? data_of(m_sel) : '0;
    e = {g, 2'(m_sel), v, to, b};
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic [3:0] r, input logic d, input bit rnd);
    logic [W+7:0] e;
    @(negedge CLK);
    REQ  = r;
    DONE = d;
    if (rnd) begin
      d0 = $urandom; d1 = $urandom; d2 = $urandom; d3 = $urandom;
    end
    model_step(r, d, e);
    exp_q.push_back(e);
    @(posedge CLK);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got %h want %h", name, $time, act, exp);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [W+7:0] e;
    logic [W+7:0] a;
    forever begin
      @(posedge CLK);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {GNT, SEL, BUS_VALID, TIMEOUT, BUS_OUT};
        n_checks++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL scoreboard t=%0t gnt=%b/%b sel=%0d/%0d valid=%b/%b timeout=%b/%b bus=%h/%h (got/want)",
                   $time, a[W+7:W+4], e[W+7:W+4], a[W+3:W+2], e[W+3:W+2],
                   a[W+1], e[W+1], a[W], e[W], a[W-1:0], e[W-1:0]);
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    $display("FAIL watchdog t=%0t bench did not finish", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0] r;
    int len;
    RST_N = 1'b0;
    REQ   = 4'b1111;
    DONE  = 1'b0;
    d0 = $urandom; d1 = $urandom; d2 = $urandom; d3 = $urandom;
    model_reset();
    repeat (3) @(posedge CLK);
    #1;
    check("reset_gnt",   GNT,       4'b0000);
    check("reset_sel",   SEL,       2'd0);
    check("reset_valid", BUS_VALID, 1'b0);
    check("reset_bus",   BUS_OUT,   '0);
    check("reset_ptr",   dbg_ptr,   2'd0);
    @(negedge CLK);
    REQ   = 4'b0000;
    RST_N = 1'b1;

    // Round-robin with DONE every grant cycle: owners 0,1,2,3,0.
    for (int k = 0; k < 5; k++) begin
      step(4'b1111, 1'b1, 1'b1);
      #1 check("rr_grant", GNT, 4'b0001 << (k % 4));
      step(4'b1111, 1'b1, 1'b1);
      #1 check("rr_idle", GNT, 4'b0000);
    end

    // Hold limit with requester 0 held and DONE low.
    for (int k = 0; k < MH; k++) begin
      step(4'b0001, 1'b0, 1'b1);
      #1 check("hold_gnt", GNT, 4'b0001);
    end
    step(4'b0001, 1'b0, 1'b1);
    #1 check("timeout_gnt", GNT, 4'b0000);
    check("timeout_pulse", TIMEOUT, 1'b1);
    step(4'b0001, 1'b0, 1'b1);
    #1 check("regrant_gnt", GNT, 4'b0001);
    check("regrant_timeout", TIMEOUT, 1'b0);
    step(4'b0001, 1'b1, 1'b1);

    // Single grant to requester 2 with fixed data.
    d2 = 32'hDEADBEEF;
    step(4'b0100, 1'b0, 1'b0);
    #1 check("single_gnt", GNT, 4'b0100);
    check("single_sel", SEL, 2'd2);
    check("single_bus", BUS_OUT, 32'hDEADBEEF);
    step(4'b0100, 1'b1, 1'b0);
    #1 check("single_rel_gnt", GNT, 4'b0000);
    check("single_rel_bus", BUS_OUT, '0);
    check("single_rel_sel", SEL, 2'd2);

    // Owner 3 drops its request: no timeout, pointer wraps to 0.
    step(4'b1000, 1'b0, 1'b1);
    step(4'b0000, 1'b0, 1'b1);
    #1 check("drop_gnt", GNT, 4'b0000);
    check("drop_timeout", TIMEOUT, 1'b0);
    check("drop_ptr", dbg_ptr, 2'd0);

    // DONE coincident with the hold limit suppresses TIMEOUT.
    step(4'b0010, 1'b0, 1'b1);
    for (int k = 1; k < MH; k++) step(4'b0010, 1'b0, 1'b1);
    step(4'b0010, 1'b1, 1'b1);
    #1 check("done_prec_gnt", GNT, 4'b0000);
    check("done_prec_timeout", TIMEOUT, 1'b0);

    // Random requests changing every cycle.
    repeat (300) step(4'($urandom_range(0, 15)), $urandom_range(0, 3) == 0, 1'b1);

    // Random requests held for bursts, so hold limits are reached.
    repeat (40) begin
      r   = 4'($urandom_range(1, 15));
      len = $urandom_range(1, 14);
      repeat (len) step(r, $urandom_range(0, 7) == 0, 1'b1);
    end

    // Asynchronous reset in the middle of a grant to requester 1.
    step(4'b0000, 1'b0, 1'b1);
    step(4'b0010, 1'b0, 1'b1);
    step(4'b0010, 1'b0, 1'b1);
    #1 check("pre_reset_gnt", GNT, 4'b0010);
    @(negedge CLK);
    #1;
    RST_N = 1'b0;
    REQ   = 4'b0000;
    #1;
    check("async_rst_gnt",     GNT,       4'b0000);
    check("async_rst_timeout", TIMEOUT,   1'b0);
    check("async_rst_valid",   BUS_VALID, 1'b0);
    check("async_rst_bus",     BUS_OUT,   '0);
    check("async_rst_ptr",     dbg_ptr,   2'd0);
    model_reset();
    #1 RST_N = 1'b1;
    step(4'b0010, 1'b0, 1'b1);
    #1 check("post_rst_gnt", GNT, 4'b0010);
    step(4'b0010, 1'b1, 1'b1);
    step(4'b0000, 1'b0, 1'b1);
    #1 check("post_rst_ptr", dbg_ptr, 2'd2);

    repeat (3) @(posedge CLK);
    #3 check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
